mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and load/store aligner between the core's instruction-fetch port and data port and one shared synchronous SRAM (1-cycle read latency). Grants at most one access per cycle, tracks which requester owns the in-flight read, and steers the returned data to that requester. Also generates store byte enables and sign/zero-extends loads from `funct3`. Sits between `cpu` and the unified memory; replaces separate instr/dmem arrays.

## Interface
- `DATA_PRIO`, default 1: 1 gives the data port priority on collision; 0 gives the fetch port priority.
- `AW`, default 32: byte address width.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, held until `if_gnt`.
- `if_addr` in AW: fetch byte address, word aligned.
- `if_gnt` out 1: fetch accepted this cycle (combinational).
- `if_rvalid` out 1: `if_rdata` valid, one cycle after `if_gnt`.
- `if_rdata` out 32: fetched instruction.
- `d_req` in 1: data request, held until `d_gnt`.
- `d_we` in 1: 1 for store, 0 for load.
- `d_funct3` in 3: RV32I width/sign code.
- `d_addr` in AW: data byte address.
- `d_wdata` in 32: store data, right-aligned (rs2).
- `d_gnt` out 1: data accepted this cycle.
- `d_rvalid` out 1: load data, store completion or error, one cycle after `d_gnt`.
- `d_rdata` out 32: extended load result; 0 for stores and errors.
- `d_err` out 1: qualifies `d_rvalid`; misaligned access or illegal `funct3`.
- `mem_en`, `mem_we` out 1: SRAM strobe and write.
- `mem_be` out 4: byte lane enables.
- `mem_addr` out AW: word address {addr[AW-1:2],2'b00}.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: SRAM read data, valid one cycle after `mem_en` with `!mem_we`.

## Operation
- Arbitration, every cycle: if one requester is active, grant it. If both are active, grant the `DATA_PRIO` winner; the loser stays pending with its `*_gnt` low.
- Throughput is one grant per cycle. A grant may coincide with the previous grant's response cycle.
- Requesters must hold address, data and control stable while `req` is high and `gnt` is low. Changes during that window are undefined.
- Response tag register `owner` holds NONE, IF, D_LOAD, D_STORE or D_ERR. It is loaded at each grant and cleared to NONE in cycles with no grant.
- `*_rvalid` is decoded from `owner` and is a 1-cycle pulse.
- Loads: `funct3` 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code raises `d_err`.
- Misaligned accesses raise `d_err`: H with addr[0]=1, W with addr[1:0]≠0.
- An error access is still granted and still gets a response. It drives `mem_en`=0, and the response has `d_err`=1 and `d_rdata`=0.
- Store byte enables:
  - SB: `mem_be` = 1<<addr[1:0], `mem_wdata` = {4{wdata[7:0]}}.
  - SH: `mem_be` = 0011 or 1100 by addr[1], `mem_wdata` = {2{wdata[15:0]}}.
  - SW: `mem_be` = 1111.
- Loads: `mem_be`=1111. Lane select and extension use addr[1:0] and `funct3` registered at grant, not live inputs.
- Stores occupy the SRAM for the grant cycle only. The `d_rvalid` completion pulse follows next cycle with `d_rdata`=0.
- Fetch is always a word read. Misaligned `if_addr` is not checked; addr[1:0] is ignored.
- When no grant is issued: `mem_en`=0. `mem_we`, `mem_be` and `mem_wdata` are 0 whenever `mem_en`=0.

## Timing
- Cycle N: `req` high and granted, so `gnt` and the `mem_*` strobes are high in N.
- Cycle N+1: `rvalid` high, with data driven from `mem_rdata` through the aligner (combinational from the SRAM output).
- Latency is 1 cycle from grant to response. A stalled requester adds 1 cycle per lost arbitration.
- Simultaneous requests with `DATA_PRIO`=1: `d_gnt` in N and `if_gnt` in N+1, provided `d_req` has dropped.
- A continuously asserted `d_req` starves fetch. This is legal because the core never issues a data request without a fetch in between.
- Reset values: `owner`=NONE, so all `*_rvalid` and `d_err` are 0. All `mem_*` outputs are 0 while `reset_n`=0, since grants are gated by `reset_n`.
- Reset asserted mid-access discards the in-flight response. The first grant after deassertion may occur in the first clock with `reset_n`=1.

## Structure
- Package `mem_pkg`:
  - `funct3` width codes: FB, FH, FW, FBU, FHU.
  - `owner_t` enum: NONE, IF, D_LOAD, D_STORE, D_ERR.
  - Byte-enable constants.
- Sub-module `lsu_align`: combinational store-lane steering, misalignment/illegal check, and load extract/extend.
- Top holds the arbitration, the `owner` register, and the registered addr[1:0]/`funct3` for the load path.

## Test plan
- Fetch only: `if_addr`=0x10, SRAM word 0x00500093 → `if_gnt` in N; `if_rvalid` with `if_rdata`=0x00500093 in N+1.
- Collision with `DATA_PRIO`=1: `if_req` and `d_req` (LW 0x20) rise together → `d_gnt` in N, `if_gnt` in N+1, `d_rvalid` in N+1, `if_rvalid` in N+2.
- SB 0x23 with `wdata`=0x000000AB → `mem_be`=1000, `mem_wdata`=0xABABABAB. LB 0x23 → `d_rdata`=0xFFFFFFAB; LBU 0x23 → 0x000000AB.
- LH at 0x41 → `mem_en`=0; next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0. `funct3`=011 gives the same error response.
- Back-to-back fetches at 0x0, 0x4, 0x8 → grants in 3 consecutive cycles, 3 consecutive `if_rvalid` pulses in order.
- `reset_n` pulled low in the cycle after a load grant → no `d_rvalid`, all `mem_*`=0; normal grant in the first cycle after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared codes for the memory arbiter: RV32I load/store width codes,
// response owner tags and byte-lane enable constants.
package mem_pkg;

    localparam logic [2:0] FB  = 3'b000;
    localparam logic [2:0] FH  = 3'b001;
    localparam logic [2:0] FW  = 3'b010;
    localparam logic [2:0] FBU = 3'b100;
    localparam logic [2:0] FHU = 3'b101;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        IF      = 3'd1,
        D_LOAD  = 3'd2,
        D_STORE = 3'd3,
        D_ERR   = 3'd4
    } owner_t;

    function automatic logic is_d_owner(input owner_t o);
        return (o == D_LOAD) || (o == D_STORE) || (o == D_ERR);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store aligner: store lane steering, access legality check
// and load byte/half extraction with sign or zero extension. No state, no stalls.
module lsu_align (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        err,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    import mem_pkg::*;

    logic        illegal;
    logic        misaligned;
    logic [31:0] shifted;

    // Unsigned widths exist only for loads; stores accept B/H/W only.
    always_comb begin
        illegal = 1'b1;
        case (funct3)
            FB, FH, FW: illegal = 1'b0;
            FBU, FHU:   illegal = we;
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            FH, FHU: misaligned = addr_lo[0];
            FW:      misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign err = illegal | misaligned;

    always_comb begin
        be         = BE_ALL;
        wdata_lane = '0;
        if (we) begin
            case (funct3)
                FB: begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                FH: begin
                    be         = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                    wdata_lane = {2{wdata[15:0]}};
                end
                default: begin
                    be         = BE_ALL;
                    wdata_lane = wdata;
                end
            endcase
        end
    end

    // Load side uses the offset/width captured at grant, not the live request.
    assign shifted = rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_funct3)
            FB:      ld_data = {{24{shifted[7]}}, shifted[7:0]};
            FBU:     ld_data = {24'h0, shifted[7:0]};
            FH:      ld_data = {{16{shifted[15]}}, shifted[15:0]};
            FHU:     ld_data = {16'h0, shifted[15:0]};
            FW:      ld_data = rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one synchronous SRAM; response 1 cycle after grant.
// Collision loser sees gnt low and must hold its request until granted.
module mem_arbiter #(
    parameter int DATA_PRIO = 1,
    parameter int AW        = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [2:0]    d_funct3,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    import mem_pkg::*;

    localparam logic [AW-1:0] WORD_MASK = ~(AW'(3));

    owner_t      owner;
    owner_t      owner_nxt;
    logic        d_win;
    logic        if_win;
    logic        acc_err;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [1:0]  ld_addr_lo;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_data;

    // Grants are gated by reset so the SRAM sees no strobes while held in reset.
    always_comb begin
        d_win  = reset_n && d_req  && ((DATA_PRIO != 0) || !if_req);
        if_win = reset_n && if_req && ((DATA_PRIO == 0) || !d_req);
    end

    assign d_gnt  = d_win;
    assign if_gnt = if_win;

    lsu_align u_align (
        .we         (d_we),
        .funct3     (d_funct3),
        .addr_lo    (d_addr[1:0]),
        .wdata      (d_wdata),
        .err        (acc_err),
        .be         (acc_be),
        .wdata_lane (acc_wdata),
        .ld_funct3  (ld_funct3),
        .ld_addr_lo (ld_addr_lo),
        .rdata      (mem_rdata),
        .ld_data    (ld_data)
    );

    always_comb begin
        owner_nxt = NONE;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = BE_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_win) begin
            if (acc_err) begin
                owner_nxt = D_ERR;
            end else begin
                owner_nxt = d_we ? D_STORE : D_LOAD;
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_be    = acc_be;
                mem_addr  = d_addr & WORD_MASK;
                mem_wdata = acc_wdata;
            end
        end else if (if_win) begin
            owner_nxt = IF;
            mem_en    = 1'b1;
            mem_be    = BE_ALL;
            mem_addr  = if_addr & WORD_MASK;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= NONE;
            ld_addr_lo <= 2'b00;
            ld_funct3  <= FW;
        end else begin
            owner <= owner_nxt;
            if (d_win && !d_we) begin
                ld_addr_lo <= d_addr[1:0];
                ld_funct3  <= d_funct3;
            end
        end
    end

    always_comb begin
        if_rvalid = (owner == IF);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rvalid  = is_d_owner(owner);
        d_err     = (owner == D_ERR);
        d_rdata   = (owner == D_LOAD) ? ld_data : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural SRAM behind it.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] sram [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_dat;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.DATA_PRIO(1), .AW(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_funct3  (d_funct3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clock) begin
        if (bd_we) begin
            sram[bd_idx] <= bd_dat;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && !mem_we) mem_rdata <= sram[mem_addr[9:2]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
        bd_idx = idx;
        bd_dat = dat;
        bd_we  = 1'b1;
        tick();
        bd_we  = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        d_req    = 1'b1;
        d_we     = we;
        d_funct3 = f3;
        d_addr   = a;
        d_wdata  = wd;
    endtask

    initial begin
        reset_n  = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_funct3 = 3'b010;
        d_addr   = '0;
        d_wdata  = '0;
        bd_we    = 1'b0;
        bd_idx   = '0;
        bd_dat   = '0;

        preload(8'd0, 32'h0000A000);
        preload(8'd1, 32'h0000A004);
        preload(8'd2, 32'h0000A008);
        preload(8'd4, 32'h00500093);
        preload(8'd8, 32'h12345678);

        // Requests while held in reset must not reach the SRAM.
        if_req = 1'b1; if_addr = 32'h10;
        drive_d(1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clock);
        chk("rst_if_gnt",    {31'b0, if_gnt},    32'h0);
        chk("rst_d_gnt",     {31'b0, d_gnt},     32'h0);
        chk("rst_mem_en",    {31'b0, mem_en},    32'h0);
        chk("rst_mem_be",    {28'b0, mem_be},    32'h0);
        chk("rst_mem_addr",  mem_addr,           32'h0);
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
        chk("rst_d_rvalid",  {31'b0, d_rvalid},  32'h0);
        chk("rst_d_err",     {31'b0, d_err},     32'h0);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        reset_n = 1'b1;
        tick();

        // Fetch only at 0x10.
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clock);
        chk("f_if_gnt",   {31'b0, if_gnt}, 32'h1);
        chk("f_d_gnt",    {31'b0, d_gnt},  32'h0);
        chk("f_mem_en",   {31'b0, mem_en}, 32'h1);
        chk("f_mem_we",   {31'b0, mem_we}, 32'h0);
        chk("f_mem_be",   {28'b0, mem_be}, 32'hF);
        chk("f_mem_addr", mem_addr,        32'h10);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        chk("f_if_rvalid", {31'b0, if_rvalid}, 32'h1);
        chk("f_if_rdata",  if_rdata,           32'h00500093);
        chk("f_d_rvalid",  {31'b0, d_rvalid},  32'h0);
        chk("f_idle_en",   {31'b0, mem_en},    32'h0);
        tick();

        // Collision: data wins, fetch follows.
        if_req = 1'b1; if_addr = 32'h0;
        drive_d(1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clock);
        chk("c_d_gnt",    {31'b0, d_gnt},  32'h1);
        chk("c_if_gnt",   {31'b0, if_gnt}, 32'h0);
        chk("c_mem_addr", mem_addr,        32'h20);
        tick();
        d_req = 1'b0;
        @(negedge clock);
        chk("c_if_gnt2",   {31'b0, if_gnt},    32'h1);
        chk("c_d_rvalid",  {31'b0, d_rvalid},  32'h1);
        chk("c_d_rdata",   d_rdata,            32'h12345678);
        chk("c_if_rvalid", {31'b0, if_rvalid}, 32'h0);
        chk("c_mem_addr2", mem_addr,           32'h0);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        chk("c_if_rvalid2", {31'b0, if_rvalid}, 32'h1);
        chk("c_if_rdata",   if_rdata,           32'h0000A000);
        chk("c_d_rvalid2",  {31'b0, d_rvalid},  32'h0);
        tick();

        // SB 0x23: word 8 becomes 0xAB345678.
        drive_d(1'b1, 3'b000, 32'h23, 32'h000000AB);
        @(negedge clock);
        chk("sb_mem_we",    {31'b0, mem_we}, 32'h1);
        chk("sb_mem_be",    {28'b0, mem_be}, 32'h8);
        chk("sb_mem_wdata", mem_wdata,       32'hABABABAB);
        chk("sb_mem_addr",  mem_addr,        32'h20);
        tick();
        d_req = 1'b0;
        @(negedge clock);
        chk("sb_rvalid", {31'b0, d_rvalid}, 32'h1);
        chk("sb_rdata",  d_rdata,           32'h0);
        chk("sb_err",    {31'b0, d_err},    32'h0);
        tick();

        // Back-to-back loads: LB 0x23, LBU 0x23, LH 0x22.
        drive_d(1'b0, 3'b000, 32'h23, 32'hFFFFFFFF);
        @(negedge clock);
        chk("lb_mem_be",    {28'b0, mem_be}, 32'hF);
        chk("lb_mem_wdata", mem_wdata,       32'h0);
        tick();
        drive_d(1'b0, 3'b100, 32'h23, 32'h0);
        @(negedge clock);
        chk("lb_rdata", d_rdata, 32'hFFFFFFAB);
        tick();
        drive_d(1'b0, 3'b001, 32'h22, 32'h0);
        @(negedge clock);
        chk("lbu_rdata", d_rdata, 32'h000000AB);
        tick();
        d_req = 1'b0;
        @(negedge clock);
        chk("lh_rdata", d_rdata, 32'hFFFFAB34);
        tick();

        // SH at 0x22 steers to the upper half.
        drive_d(1'b1, 3'b001, 32'h22, 32'h0000BEEF);
        @(negedge clock);
        chk("sh_mem_be",    {28'b0, mem_be}, 32'hC);
        chk("sh_mem_wdata", mem_wdata,       32'hBEEFBEEF);
        tick();
        d_req = 1'b0;
        tick();

        // Misaligned LH, then illegal funct3 011.
        drive_d(1'b0, 3'b001, 32'h41, 32'h0);
        @(negedge clock);
        chk("mis_d_gnt",  {31'b0, d_gnt},  32'h1);
        chk("mis_mem_en", {31'b0, mem_en}, 32'h0);
        chk("mis_mem_be", {28'b0, mem_be}, 32'h0);
        tick();
        drive_d(1'b0, 3'b011, 32'h40, 32'h0);
        @(negedge clock);
        chk("mis_rvalid", {31'b0, d_rvalid}, 32'h1);
        chk("mis_err",    {31'b0, d_err},    32'h1);
        chk("mis_rdata",  d_rdata,           32'h0);
        chk("ill_mem_en", {31'b0, mem_en},   32'h0);
        tick();
        d_req = 1'b0;
        @(negedge clock);
        chk("ill_rvalid", {31'b0, d_rvalid}, 32'h1);
        chk("ill_err",    {31'b0, d_err},    32'h1);
        chk("ill_rdata",  d_rdata,           32'h0);
        tick();

        // Back-to-back fetches at 0x0, 0x4, 0x8.
        if_req = 1'b1; if_addr = 32'h0;
        @(negedge clock);
        chk("bb_gnt0", {31'b0, if_gnt}, 32'h1);
        tick();
        if_addr = 32'h4;
        @(negedge clock);
        chk("bb_gnt1",   {31'b0, if_gnt},    32'h1);
        chk("bb_rv0",    {31'b0, if_rvalid}, 32'h1);
        chk("bb_rdata0", if_rdata,           32'h0000A000);
        tick();
        if_addr = 32'h8;
        @(negedge clock);
        chk("bb_gnt2",   {31'b0, if_gnt},    32'h1);
        chk("bb_rv1",    {31'b0, if_rvalid}, 32'h1);
        chk("bb_rdata1", if_rdata,           32'h0000A004);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        chk("bb_rv2",    {31'b0, if_rvalid}, 32'h1);
        chk("bb_rdata2", if_rdata,           32'h0000A008);
        tick();
        @(negedge clock);
        chk("bb_rv_end", {31'b0, if_rvalid}, 32'h0);
        tick();

        // Reset in the cycle after a load grant drops the response.
        drive_d(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clock);
        chk("rr_d_gnt", {31'b0, d_gnt}, 32'h1);
        tick();
        d_req = 1'b0;
        reset_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clock);
        chk("rr_d_rvalid",  {31'b0, d_rvalid}, 32'h0);
        chk("rr_if_gnt",    {31'b0, if_gnt},   32'h0);
        chk("rr_mem_en",    {31'b0, mem_en},   32'h0);
        chk("rr_mem_we",    {31'b0, mem_we},   32'h0);
        chk("rr_mem_be",    {28'b0, mem_be},   32'h0);
        chk("rr_mem_addr",  mem_addr,          32'h0);
        chk("rr_mem_wdata", mem_wdata,         32'h0);
        tick();
        reset_n = 1'b1;
        @(negedge clock);
        chk("rr_if_gnt2",   {31'b0, if_gnt}, 32'h1);
        chk("rr_mem_en2",   {31'b0, mem_en}, 32'h1);
        chk("rr_mem_addr2", mem_addr,        32'h10);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        chk("rr_if_rvalid", {31'b0, if_rvalid}, 32'h1);
        chk("rr_if_rdata",  if_rdata,           32'h00500093);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
